// File: rtl/ir_ac_receiver_pkg.sv
// Shared definitions for the AC IR link: frame geometry, nominal TX timings and FSM state encoding.
package ir_ac_receiver_pkg;

  localparam int DATA35_BITS = 35;
  localparam int DATA32_BITS = 32;
  localparam int FRAME_BITS  = DATA35_BITS + DATA32_BITS;
  localparam int DUR_W       = 22;

  // Nominal transmitter timings in microseconds.
  localparam int LEAD_MK_US = 9000;
  localparam int LEAD_SP_US = 4500;
  localparam int ZERO_MK_US = 750;
  localparam int ONE_MK_US  = 1550;
  localparam int BIT_SP_US  = 550;
  localparam int CONN_MK_US = 750;
  localparam int CONN_SP_US = 19250;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEAD_MK,
    ST_LEAD_SP,
    ST_BIT_MK,
    ST_BIT_SP,
    ST_CONN_MK,
    ST_CONN_MARK_HI,
    ST_CONN_SP,
    ST_DONE
  } ir_state_t;

  function automatic logic in_window(input logic [31:0] d, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_ac_receiver_sync_filter.sv
// Synchronizes the raw IR line and only follows a level once it has been stable for FILT_CYCLES clocks.
module ir_rx_sync_filter #(
  parameter int unsigned FILT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic sync1, sync2;
  logic [CW-1:0] cnt;

  // cnt measures how long the synchronized line has disagreed with lvl; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt  <= '0;
        lvl  <= sync2;
        rise <= sync2;
        fall <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_ac_receiver.sv
// AC IR frame decoder: lead, 35 bits, connect code, 32 bits; reports the command with a valid or error pulse.
module ir_ac_receiver
  import ir_ac_receiver_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 1000,
  parameter int unsigned LEAD_MK_MIN = 800000,
  parameter int unsigned LEAD_MK_MAX = 1000000,
  parameter int unsigned LEAD_SP_MIN = 400000,
  parameter int unsigned LEAD_SP_MAX = 500000,
  parameter int unsigned ZERO_MK_MIN = 60000,
  parameter int unsigned ZERO_MK_MAX = 100000,
  parameter int unsigned ONE_MK_MIN  = 130000,
  parameter int unsigned ONE_MK_MAX  = 180000,
  parameter int unsigned BIT_SP_MIN  = 30000,
  parameter int unsigned BIT_SP_MAX  = 100000,
  parameter int unsigned CONN_SP_MIN = 1500000,
  parameter int unsigned CONN_SP_MAX = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IR_in,
  output logic [DATA35_BITS-1:0] data35_out,
  output logic [DATA32_BITS-1:0] data32_out,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned ARM_CYCLES = 2 * FILT_CYCLES + 4;

  ir_state_t             state;
  logic                  lvl, rise, fall;
  logic                  armed;
  logic [DUR_W-1:0]      dur;
  logic [31:0]           dur_ext;
  logic [6:0]            bitcnt, bitcnt_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  close_edge, win_ok, timed, timeout, is_zero, is_one;
  logic [31:0]           phase_max;

  ir_rx_sync_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filter (
    .clk   (clk),
    .rst   (rst),
    .ir_in (IR_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  assign dur_ext    = {{(32-DUR_W){1'b0}}, dur};
  assign bitcnt_nxt = bitcnt + 7'd1;
  assign is_zero    = in_window(dur_ext, ZERO_MK_MIN, ZERO_MK_MAX);
  assign is_one     = in_window(dur_ext, ONE_MK_MIN, ONE_MK_MAX);
  assign timeout    = timed && (dur_ext > phase_max);

  // A line already high when reset ends would look like a rise once the filter settles; wait for a real low first.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur   <= '0;
      armed <= 1'b0;
    end else begin
      if (rise || fall)  dur <= '0;
      else if (dur != '1) dur <= dur + 1'b1;
      if (!lvl && dur_ext >= ARM_CYCLES) armed <= 1'b1;
    end
  end

  always_comb begin
    close_edge = 1'b0;
    win_ok     = 1'b0;
    phase_max  = '0;
    timed      = 1'b1;
    case (state)
      ST_LEAD_MK:      begin close_edge = fall; phase_max = LEAD_MK_MAX;
                             win_ok = in_window(dur_ext, LEAD_MK_MIN, LEAD_MK_MAX); end
      ST_LEAD_SP:      begin close_edge = rise; phase_max = LEAD_SP_MAX;
                             win_ok = in_window(dur_ext, LEAD_SP_MIN, LEAD_SP_MAX); end
      ST_BIT_MK:       begin close_edge = fall; phase_max = ONE_MK_MAX;
                             win_ok = is_zero || is_one; end
      ST_BIT_SP,
      ST_CONN_MK:      begin close_edge = rise; phase_max = BIT_SP_MAX;
                             win_ok = in_window(dur_ext, BIT_SP_MIN, BIT_SP_MAX); end
      ST_CONN_MARK_HI: begin close_edge = fall; phase_max = ZERO_MK_MAX;
                             win_ok = is_zero; end
      ST_CONN_SP:      begin close_edge = rise; phase_max = CONN_SP_MAX;
                             win_ok = in_window(dur_ext, CONN_SP_MIN, CONN_SP_MAX); end
      default:         timed = 1'b0;
    endcase
  end

  // A closing edge is judged only by its window, so it overrides a timeout arriving in the same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      data35_out  <= '0;
      data32_out  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= (state != ST_IDLE);
      if (state == ST_IDLE) begin
        if (rise && armed) state <= ST_LEAD_MK;
      end else if (state == ST_DONE) begin
        data35_out  <= shreg[FRAME_BITS-1:DATA32_BITS];
        data32_out  <= shreg[DATA32_BITS-1:0];
        frame_valid <= 1'b1;
        state       <= ST_IDLE;
      end else if (close_edge ? !win_ok : timeout) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
        shreg     <= '0;
        bitcnt    <= '0;
      end else if (close_edge) begin
        case (state)
          ST_LEAD_MK: state <= ST_LEAD_SP;
          ST_LEAD_SP: begin
            state  <= ST_BIT_MK;
            bitcnt <= '0;
            shreg  <= '0;
          end
          ST_BIT_MK: begin
            shreg  <= {shreg[FRAME_BITS-2:0], is_one};
            bitcnt <= bitcnt_nxt;
            if (bitcnt_nxt == 7'(DATA35_BITS))     state <= ST_CONN_MK;
            else if (bitcnt_nxt == 7'(FRAME_BITS)) state <= ST_DONE;
            else                                   state <= ST_BIT_SP;
          end
          ST_BIT_SP, ST_CONN_SP: state <= ST_BIT_MK;
          ST_CONN_MK:            state <= ST_CONN_MARK_HI;
          ST_CONN_MARK_HI:       state <= ST_CONN_SP;
          default:               state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_ac_receiver.sv
// Directed bench for ir_ac_receiver with timings scaled to 20us per clock and a 4-clock filter.
module tb_ir_ac_receiver;
  import ir_ac_receiver_pkg::*;

  localparam int US_PER_CLK = 20;
  localparam int FILT       = 4;
  localparam int LEAD_MK    = LEAD_MK_US / US_PER_CLK;
  localparam int LEAD_SP    = LEAD_SP_US / US_PER_CLK;
  localparam int ZERO_MK    = ZERO_MK_US / US_PER_CLK;
  localparam int ONE_MK     = ONE_MK_US / US_PER_CLK;
  localparam int BIT_SP     = BIT_SP_US / US_PER_CLK;
  localparam int CONN_MK    = CONN_MK_US / US_PER_CLK;
  localparam int CONN_SP    = CONN_SP_US / US_PER_CLK;

  localparam logic [34:0] D35_A = 35'h410800A52;
  localparam logic [31:0] D32_A = 32'h08040006;
  localparam logic [34:0] D35_B = 35'h5A5A50F0F;
  localparam logic [31:0] D32_B = 32'h1234ABCD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IR_in;
  logic [34:0] data35_out;
  logic [31:0] data32_out;
  logic        frame_valid, frame_err, busy;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ir_ac_receiver #(
    .FILT_CYCLES(FILT),
    .LEAD_MK_MIN(400), .LEAD_MK_MAX(500),
    .LEAD_SP_MIN(200), .LEAD_SP_MAX(250),
    .ZERO_MK_MIN(30),  .ZERO_MK_MAX(50),
    .ONE_MK_MIN(65),   .ONE_MK_MAX(90),
    .BIT_SP_MIN(15),   .BIT_SP_MAX(50),
    .CONN_SP_MIN(750), .CONN_SP_MAX(1250)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IR_in       (IR_in),
    .data35_out  (data35_out),
    .data32_out  (data32_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (frame_valid && frame_err) both_cnt++;
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [66:0] got, input logic [66:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int jt(input int n, input bit j);
    if (!j) return n;
    return n - n / 10 + int'($urandom_range(n / 5));
  endfunction

  task automatic hold(input logic lv, input int n);
    IR_in = lv;
    repeat (n) @(negedge clk);
  endtask

  // Optional 2-clock high glitch in the middle of a space, shorter than the filter.
  task automatic send_space(input int n, input bit glitch);
    if (glitch && n > 8) begin
      hold(1'b0, n / 2 - 1);
      hold(1'b1, 2);
      hold(1'b0, n - n / 2 - 1);
    end else begin
      hold(1'b0, n);
    end
  endtask

  task automatic send_frame(input logic [34:0] d35, input logic [31:0] d32, input int bad_bit,
                            input int bad_len, input int stop_bit, input bit jit, input bit glitch);
    logic [66:0] bits;
    int mk;
    bits = {d35, d32};
    hold(1'b1, jt(LEAD_MK, jit));
    send_space(jt(LEAD_SP, jit), glitch);
    for (int i = 0; i < 67; i++) begin
      if (i == stop_bit) return;
      mk = bits[66-i] ? ONE_MK : ZERO_MK;
      if (i == bad_bit) mk = bad_len;
      hold(1'b1, jt(mk, jit));
      if (i == bad_bit || i == 66) begin
        IR_in = 1'b0;
        return;
      end
      if (i == 34) begin
        send_space(jt(BIT_SP, jit), glitch);
        hold(1'b1, jt(CONN_MK, jit));
        send_space(jt(CONN_SP, jit), glitch);
      end else begin
        send_space(jt(BIT_SP, jit), glitch);
      end
    end
  endtask

  task automatic wait_pulse(input bit want_err, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (want_err ? frame_err : frame_valid) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int first;
    IR_in = 1'b0;
    repeat (5) @(negedge clk);
    check_output("rst_data35", 67'(data35_out), 67'd0);
    check_output("rst_data32", 67'(data32_out), 67'd0);
    check_output("rst_valid", 67'(frame_valid), 67'd0);
    check_output("rst_err", 67'(frame_err), 67'd0);
    check_output("rst_busy", 67'(busy), 67'd0);
    rst = 1'b0;
    hold(1'b0, 50);

    // 1: nominal frame; valid lands FILT+4 clocks after the last mark is dropped
    send_frame(D35_A, D32_A, -1, 0, -1, 1'b0, 1'b0);
    wait_pulse(1'b0, 40, n);
    check_output("t1_latency", 67'(n), 67'(FILT + 4));
    check_output("t1_busy_at_valid", 67'(busy), 67'd1);
    @(negedge clk);
    check_output("t1_valid_width", 67'(frame_valid), 67'd0);
    check_output("t1_busy_after", 67'(busy), 67'd0);
    hold(1'b0, 30);
    check_output("t1_data35", 67'(data35_out), 67'(D35_A));
    check_output("t1_data32", 67'(data32_out), 67'(D32_A));
    check_output("t1_valid_cnt", 67'(valid_cnt), 67'd1);
    check_output("t1_err_cnt", 67'(err_cnt), 67'd0);

    // 2: 7ms lead mark rejected at its fall
    hold(1'b1, 7000 / US_PER_CLK);
    IR_in = 1'b0;
    wait_pulse(1'b1, 40, n);
    check_output("t2_err_latency", 67'(n), 67'(FILT + 3));
    hold(1'b0, 30);
    check_output("t2_err_cnt", 67'(err_cnt), 67'd1);
    check_output("t2_valid_cnt", 67'(valid_cnt), 67'd1);
    check_output("t2_data35_kept", 67'(data35_out), 67'(D35_A));

    // 3: bit 10 mark of 1.1ms falls between the zero and one windows
    send_frame(D35_A, D32_A, 10, 1100 / US_PER_CLK, -1, 1'b0, 1'b0);
    wait_pulse(1'b1, 40, n);
    check_output("t3_err_latency", 67'(n), 67'(FILT + 3));
    hold(1'b0, 30);
    check_output("t3_err_cnt", 67'(err_cnt), 67'd2);
    check_output("t3_data32_kept", 67'(data32_out), 67'(D32_A));

    // 4: 12ms high line; error once dur passes LEAD_MK_MAX (500) while still high
    IR_in = 1'b1;
    first = -1;
    for (int k = 1; k <= 12000 / US_PER_CLK; k++) begin
      @(negedge clk);
      if (frame_err && first < 0) first = k;
    end
    check_output("t4_timeout_at", 67'(first), 67'(500 + FILT + 5));
    hold(1'b0, 40);
    check_output("t4_err_cnt", 67'(err_cnt), 67'd3);
    check_output("t4_valid_cnt", 67'(valid_cnt), 67'd1);

    // 5: jitter plus sub-filter glitches in every space
    send_frame(D35_B, D32_B, -1, 0, -1, 1'b1, 1'b1);
    wait_pulse(1'b0, 40, n);
    check_output("t5_latency", 67'(n), 67'(FILT + 4));
    hold(1'b0, 30);
    check_output("t5_data35", 67'(data35_out), 67'(D35_B));
    check_output("t5_data32", 67'(data32_out), 67'(D32_B));
    check_output("t5_err_cnt", 67'(err_cnt), 67'd3);

    // 6: reset in the middle of the frame, then a clean frame
    send_frame(D35_A, D32_A, -1, 0, 40, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("t6_rst_data35", 67'(data35_out), 67'd0);
    check_output("t6_rst_data32", 67'(data32_out), 67'd0);
    check_output("t6_rst_busy", 67'(busy), 67'd0);
    check_output("t6_rst_err", 67'(frame_err), 67'd0);
    rst = 1'b0;
    hold(1'b0, 50);
    check_output("t6_no_pulse_err", 67'(err_cnt), 67'd3);
    check_output("t6_no_pulse_valid", 67'(valid_cnt), 67'd2);
    send_frame(D35_A, D32_A, -1, 0, -1, 1'b0, 1'b0);
    wait_pulse(1'b0, 40, n);
    check_output("t6_latency", 67'(n), 67'(FILT + 4));
    hold(1'b0, 30);
    check_output("t6_data35", 67'(data35_out), 67'(D35_A));
    check_output("t6_data32", 67'(data32_out), 67'(D32_A));
    check_output("t6_valid_cnt", 67'(valid_cnt), 67'd3);
    check_output("both_pulses", 67'(both_cnt), 67'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
